// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants for the Clause-22 MDIO responder and controller.
//   Frame codes (ST/OP/TA), field widths, FSM state encodings, frame bit
//   indices and the ID register indices.
package mdio_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 32;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    localparam logic [4:0] REG_ID_HI = 5'd2;
    localparam logic [4:0] REG_ID_LO = 5'd3;

    // FSM state encodings (legacy-compatible constants)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ST    = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_DATA  = 3'd6;
    localparam logic [2:0] S_SKIP  = 3'd7;

    // Frame bit index of the last bit of each field (ST bit 0 is index 0)
    localparam logic [4:0] IDX_OP_END  = 5'd3;
    localparam logic [4:0] IDX_PHY_END = 5'd8;
    localparam logic [4:0] IDX_REG_END = 5'd13;
    localparam logic [4:0] IDX_TA1     = 5'd14;
    localparam logic [4:0] IDX_TA2     = 5'd15;
    localparam logic [4:0] IDX_LAST    = 5'd31;

    // True for the read-only PHY identifier registers
    function automatic logic is_id_reg(input logic [4:0] addr);
        return (addr == REG_ID_HI) || (addr == REG_ID_LO);
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: synchronizes mdc and mdio into the clk domain and flags
//   mdc rising/falling edges on the synchronized copy. Both inputs go through
//   the same number of flops so the sampled data bit lines up with the edge.
// Ports:
//   clk, reset    system clock, synchronous active-low reset
//   i_mdc, i_mdio asynchronous management clock / data
//   o_mdc_rise    one-clk pulse on synchronized mdc 0->1
//   o_mdc_fall    one-clk pulse on synchronized mdc 1->0
//   o_mdio        synchronized mdio
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdc_rise,
    output logic o_mdc_fall,
    output logic o_mdio
);

    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdio_sync;
    logic                   r_mdc_prev;

    // Synchronizer chains plus the delayed mdc copy for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mdc_sync  <= '0;
            r_mdio_sync <= '0;
            r_mdc_prev  <= 1'b0;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], i_mdc};
            r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], i_mdio};
            r_mdc_prev  <= r_mdc_sync[SYNC_STAGES-1];
        end
    end

    assign o_mdc_rise = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_prev;
    assign o_mdc_fall = ~r_mdc_sync[SYNC_STAGES-1] & r_mdc_prev;
    assign o_mdio     = r_mdio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: PHY-side Clause-22 MDIO responder with a 32x16 register
//   file. Decodes ST/OP/PHYAD/REGAD/TA/DATA frames sampled on mdc rise,
//   writes the register file on write frames and serializes read data on
//   mdc fall. Regs 2/3 are read-only PHY identifiers.
// Optional feature: MDIO_PREAMBLE_EN requires >=32 consecutive 1s in IDLE
//   before a 0 is accepted as the start of frame.
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   mdc, mdio_in         management clock / serial data from controller
//   mdio_out, mdio_oe    serial read data and its drive enable
//   wr_stb/addr/data     one-clk write pulse with REGAD and data of last write
//   frame_err            one-clk pulse on bad ST/OP or bad write TA
//   usr_addr, usr_rdata  local combinational read port
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [15:0] PHY_ID_HI   = 16'h0022,
    parameter logic [15:0] PHY_ID_LO   = 16'h1620,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    input  logic [4:0]  usr_addr,
    output logic [15:0] usr_rdata
);

    logic        w_rise;
    logic        w_fall;
    logic        w_mdio;

    logic [2:0]  r_state;
    logic [4:0]  r_bit_cnt;
    logic [14:0] r_shift;
    logic        r_is_rd;
    logic [4:0]  r_regad;
    logic [15:0] r_rd_data;
    logic        r_wr_stb;
    logic [4:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_frame_err;
    logic [15:0] r_regfile [NUM_REGS];
    logic [16:0] r_out_sr;
    logic [4:0]  r_out_cnt;
    logic        r_mdio_out;
    logic        r_mdio_oe;
`ifdef MDIO_PREAMBLE_EN
    logic [5:0]  r_pre_cnt;
`endif

    logic        w_rf_we;
    logic [15:0] w_rf_wdata;
    logic        w_rd_load;
    logic [15:0] w_reg_word;

    mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_mdc      (mdc),
        .i_mdio     (mdio_in),
        .o_mdc_rise (w_rise),
        .o_mdc_fall (w_fall),
        .o_mdio     (w_mdio)
    );

    assign w_rf_wdata = {r_shift, w_mdio};
    assign w_rf_we    = w_rise && (r_state == S_DATA) && (r_bit_cnt == IDX_LAST)
                        && !r_is_rd && !is_id_reg(r_regad);
    // Read shifter loads on TA bit 1 so the first drive lands on the next fall
    assign w_rd_load  = w_rise && (r_state == S_TA) && (r_bit_cnt == IDX_TA1) && r_is_rd;

    // Register word addressed by the REGAD field currently being completed
    always_comb begin
        w_reg_word = 16'h0000;
        if ({r_shift[3:0], w_mdio} == REG_ID_HI) begin
            w_reg_word = PHY_ID_HI;
        end else if ({r_shift[3:0], w_mdio} == REG_ID_LO) begin
            w_reg_word = PHY_ID_LO;
        end else begin
            w_reg_word = r_regfile[{r_shift[3:0], w_mdio}];
        end
    end

    // Local read port, independent of MDIO traffic
    always_comb begin
        usr_rdata = 16'h0000;
        if (usr_addr == REG_ID_HI) begin
            usr_rdata = PHY_ID_HI;
        end else if (usr_addr == REG_ID_LO) begin
            usr_rdata = PHY_ID_LO;
        end else begin
            usr_rdata = r_regfile[usr_addr];
        end
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regfile[i] <= 16'h0000;
            end
        end else if (w_rf_we) begin
            r_regfile[r_regad] <= w_rf_wdata;
        end else begin
            r_regfile[r_regad] <= r_regfile[r_regad];
        end
    end

    // Frame decode FSM, advanced by sampled mdc rising edges
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 5'd0;
            r_shift     <= 15'd0;
            r_is_rd     <= 1'b0;
            r_regad     <= 5'd0;
            r_rd_data   <= 16'h0000;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= 16'h0000;
            r_frame_err <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
            r_pre_cnt   <= 6'd0;
`endif
        end else begin
            r_wr_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_rise) begin
                r_shift   <= {r_shift[13:0], w_mdio};
                r_bit_cnt <= r_bit_cnt + 5'd1;
                case (r_state)
                    S_IDLE: begin
`ifdef MDIO_PREAMBLE_EN
                        // A 0 only starts a frame after a full preamble
                        if (w_mdio) begin
                            r_bit_cnt <= 5'd0;
                            if (r_pre_cnt != 6'd32) begin
                                r_pre_cnt <= r_pre_cnt + 6'd1;
                            end else begin
                                r_pre_cnt <= r_pre_cnt;
                            end
                        end else if (r_pre_cnt == 6'd32) begin
                            r_state   <= S_ST;
                            r_bit_cnt <= 5'd1;
                            r_pre_cnt <= 6'd0;
                        end else begin
                            r_bit_cnt <= 5'd0;
                            r_pre_cnt <= 6'd0;
                        end
`else
                        if (!w_mdio) begin
                            r_state   <= S_ST;
                            r_bit_cnt <= 5'd1;
                        end else begin
                            r_bit_cnt <= 5'd0;
                        end
`endif
                    end
                    S_ST: begin
                        if (w_mdio) begin
                            r_state <= S_OP;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                            r_bit_cnt   <= 5'd0;
                        end
                    end
                    S_OP: begin
                        if (r_bit_cnt == IDX_OP_END) begin
                            if ({r_shift[0], w_mdio} == OP_WR) begin
                                r_is_rd <= 1'b0;
                                r_state <= S_PHYAD;
                            end else if ({r_shift[0], w_mdio} == OP_RD) begin
                                r_is_rd <= 1'b1;
                                r_state <= S_PHYAD;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_SKIP;
                            end
                        end else begin
                            r_state <= S_OP;
                        end
                    end
                    S_PHYAD: begin
                        if (r_bit_cnt == IDX_PHY_END) begin
                            if ({r_shift[3:0], w_mdio} == PHY_ADDR) begin
                                r_state <= S_REGAD;
                            end else begin
                                r_state <= S_SKIP;
                            end
                        end else begin
                            r_state <= S_PHYAD;
                        end
                    end
                    S_REGAD: begin
                        if (r_bit_cnt == IDX_REG_END) begin
                            r_regad   <= {r_shift[3:0], w_mdio};
                            r_rd_data <= w_reg_word;
                            r_state   <= S_TA;
                        end else begin
                            r_state <= S_REGAD;
                        end
                    end
                    S_TA: begin
                        if (r_bit_cnt == IDX_TA2) begin
                            if (!r_is_rd && ({r_shift[0], w_mdio} != TA_WR)) begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_SKIP;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_state <= S_TA;
                        end
                    end
                    S_DATA: begin
                        if (r_bit_cnt == IDX_LAST) begin
                            if (w_rf_we) begin
                                r_wr_stb  <= 1'b1;
                                r_wr_addr <= r_regad;
                                r_wr_data <= w_rf_wdata;
                            end else begin
                                r_wr_stb  <= 1'b0;
                            end
                            r_state   <= S_IDLE;
                            r_bit_cnt <= 5'd0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_SKIP: begin
                        // Swallow the rest of a foreign or bad frame so its
                        // data bits cannot look like a new start of frame
                        if (r_bit_cnt == IDX_LAST) begin
                            r_state   <= S_IDLE;
                            r_bit_cnt <= 5'd0;
                        end else begin
                            r_state <= S_SKIP;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_bit_cnt <= 5'd0;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    // Read serializer: TA zero, 16 data bits, then release, all on mdc fall
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_sr   <= 17'd0;
            r_out_cnt  <= 5'd0;
            r_mdio_out <= 1'b0;
            r_mdio_oe  <= 1'b0;
        end else if (w_rd_load) begin
            r_out_sr  <= {1'b0, r_rd_data};
            r_out_cnt <= 5'd17;
        end else if (w_fall) begin
            if (r_out_cnt != 5'd0) begin
                r_mdio_oe  <= 1'b1;
                r_mdio_out <= r_out_sr[16];
                r_out_sr   <= {r_out_sr[15:0], 1'b0};
                r_out_cnt  <= r_out_cnt - 5'd1;
            end else begin
                r_mdio_oe  <= 1'b0;
                r_mdio_out <= 1'b0;
            end
        end else begin
            r_out_cnt <= r_out_cnt;
        end
    end

    assign mdio_out  = r_mdio_out;
    assign mdio_oe   = r_mdio_oe;
    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed self-checking bench for mdio_responder.
//   Drives MDIO frames bit by bit (mdc = clk/8), captures mdio_out/mdio_oe
//   just before each mdc rise, and counts strobe/error/drive cycles.
//   Build with MDIO_PREAMBLE_EN to prefix every frame with 32 ones and run
//   the preamble-length checks.
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oe;
    logic        wr_stb;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [4:0]  usr_addr;
    logic [15:0] usr_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_stb    = 0;
    int n_err    = 0;
    int n_oe     = 0;

    always #5 clk = ~clk;

    mdio_responder dut (
        .clk       (clk),
        .reset     (reset),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .usr_addr  (usr_addr),
        .usr_rdata (usr_rdata)
    );

    // Pulse / drive-cycle counters, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_stb)    n_stb = n_stb + 1;
        if (frame_err) n_err = n_err + 1;
        if (mdio_oe)   n_oe  = n_oe + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One mdc period; returns out/oe as seen by the controller at the rise
    task automatic send_bit(input logic b, output logic o, output logic e);
        mdio_in = b;
        repeat (4) @(posedge clk);
        #1;
        o   = mdio_out;
        e   = mdio_oe;
        mdc = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mdc = 1'b0;
    endtask

    task automatic send_ones(input int n);
        logic o, e;
        for (int i = 0; i < n; i++) send_bit(1'b1, o, e);
    endtask

    // 32 raw frame bits MSB first; ob/eb collect out/oe, frame bit 0 ends in [31]
    task automatic send_word(input logic [31:0] f, output logic [31:0] ob, output logic [31:0] eb);
        logic o, e;
        ob = 32'd0;
        eb = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            send_bit(f[i], o, e);
            ob = {ob[30:0], o};
            eb = {eb[30:0], e};
        end
        mdio_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] f, output logic [31:0] ob, output logic [31:0] eb);
`ifdef MDIO_PREAMBLE_EN
        send_ones(32);
`endif
        send_word(f, ob, eb);
    endtask

    initial begin
        logic [31:0] ob, eb;
        int s_stb, s_err, s_oe;
        logic o, e;

        reset    = 1'b0;
        mdc      = 1'b0;
        mdio_in  = 1'b1;
        usr_addr = 5'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_oe",    {31'd0, mdio_oe},   32'd0);
        check_eq("rst_out",   {31'd0, mdio_out},  32'd0);
        check_eq("rst_stb",   {31'd0, wr_stb},    32'd0);
        check_eq("rst_waddr", {27'd0, wr_addr},   32'd0);
        check_eq("rst_wdata", {16'd0, wr_data},   32'd0);
        check_eq("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check_eq("rst_usr4",  {16'd0, usr_rdata}, 32'd0);
        usr_addr = 5'd2;
        #1;
        check_eq("rst_usr2",  {16'd0, usr_rdata}, 32'h0022);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Write reg 4 = BEEF
        s_stb = n_stb; s_err = n_err; s_oe = n_oe;
        send_frame(32'h5092BEEF, ob, eb);
        check_eq("wr4_stb",   n_stb - s_stb, 32'd1);
        check_eq("wr4_addr",  {27'd0, wr_addr}, 32'd4);
        check_eq("wr4_data",  {16'd0, wr_data}, 32'hBEEF);
        check_eq("wr4_oe",    n_oe - s_oe, 32'd0);
        check_eq("wr4_ferr",  n_err - s_err, 32'd0);
        usr_addr = 5'd4;
        #1;
        check_eq("wr4_usr",   {16'd0, usr_rdata}, 32'hBEEF);

        // Read reg 4: TA zero then BEEF, oe from the fall after TA bit 1
        send_frame(32'h6092FFFF, ob, eb);
        check_eq("rd4_oe",    eb, 32'h0001FFFF);
        check_eq("rd4_data",  ob, 32'h0000BEEF);
        check_eq("rd4_rel",   {31'd0, mdio_oe}, 32'd0);

        // Read reg 2 (ID high)
        send_frame(32'h608AFFFF, ob, eb);
        check_eq("rd2_data",  ob, 32'h00000022);

        // Write reg 3 is ignored silently
        s_stb = n_stb; s_err = n_err;
        send_frame(32'h508E0000, ob, eb);
        check_eq("wr3_stb",   n_stb - s_stb, 32'd0);
        check_eq("wr3_ferr",  n_err - s_err, 32'd0);
        send_frame(32'h608EFFFF, ob, eb);
        check_eq("rd3_data",  ob, 32'h00001620);

        // Foreign PHYAD 7: write and read both ignored
        s_stb = n_stb; s_oe = n_oe;
        send_frame(32'h53961234, ob, eb);
        send_frame(32'h6396FFFF, ob, eb);
        check_eq("phy7_stb",  n_stb - s_stb, 32'd0);
        check_eq("phy7_oe",   n_oe - s_oe, 32'd0);
        s_stb = n_stb;
        send_frame(32'h5096A5C3, ob, eb);
        check_eq("wr5_stb",   n_stb - s_stb, 32'd1);
        check_eq("wr5_addr",  {27'd0, wr_addr}, 32'd5);
        usr_addr = 5'd5;
        #1;
        check_eq("wr5_usr",   {16'd0, usr_rdata}, 32'hA5C3);

        // OP=11 and write TA=00 flag frame_err, regfile untouched
        s_stb = n_stb; s_err = n_err;
        send_frame(32'h70920000, ob, eb);
        check_eq("op11_ferr", n_err - s_err, 32'd1);
        s_err = n_err;
        send_frame(32'h50901111, ob, eb);
        check_eq("ta00_ferr", n_err - s_err, 32'd1);
        check_eq("bad_stb",   n_stb - s_stb, 32'd0);
        usr_addr = 5'd4;
        #1;
        check_eq("bad_usr4",  {16'd0, usr_rdata}, 32'hBEEF);

        // Reset in the middle of a read of reg 4 (after data bit 8)
`ifdef MDIO_PREAMBLE_EN
        send_ones(32);
`endif
        for (int i = 31; i >= 8; i--) begin
            logic [31:0] fr;
            fr = 32'h6092FFFF;
            send_bit(fr[i], o, e);
        end
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_oe",    {31'd0, mdio_oe}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstm_oe",   {31'd0, mdio_oe},  32'd0);
        check_eq("rstm_out",  {31'd0, mdio_out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mdio_in = 1'b1;
        #1;
        check_eq("rstm_usr4", {16'd0, usr_rdata}, 32'd0);
        s_stb = n_stb;
        send_frame(32'h509A0F0F, ob, eb);
        check_eq("wr6_stb",   n_stb - s_stb, 32'd1);
        check_eq("wr6_addr",  {27'd0, wr_addr}, 32'd6);
        check_eq("wr6_data",  {16'd0, wr_data}, 32'h0F0F);

`ifdef MDIO_PREAMBLE_EN
        // 31 ones is too short; 32 ones is enough
        s_stb = n_stb;
        send_bit(1'b0, o, e);
        send_ones(31);
        send_word(32'h509E7770, ob, eb);
        check_eq("pre31_stb", n_stb - s_stb, 32'd0);
        s_stb = n_stb;
        send_ones(32);
        send_word(32'h509E7777, ob, eb);
        check_eq("pre32_stb", n_stb - s_stb, 32'd1);
        check_eq("pre32_dat", {16'd0, wr_data}, 32'h7777);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
